sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares one single-port byte-write SRAM (1-cycle registered read, zero output when not enabled)
//  between two requesters using the native valid/ready/addr/wdata/wstrb memory interface.
//  Sits between the CPU instruction port (m0), a DMA/loader data port (m1) and the SRAM model.
//  Registers each granted request, drives one SRAM access, then returns a one-cycle ready with read data.
// PARAMETERS
//  NB_COL     4     bytes per word; must be a power of 2; equals SRAM NB_COL
//  COL_WIDTH  8     bits per byte lane; equals SRAM COL_WIDTH
//  RAM_DEPTH  8192  SRAM words; localparam AW = clogb2(RAM_DEPTH-1), DW = NB_COL*COL_WIDTH
// PORTS
//  clk          in   1       clock; every register clocked on posedge
//  resetn       in   1       asynchronous active-low reset
//  m0_valid     in   1       requester 0 request; held with addr/wdata/wstrb until m0_ready
//  m0_ready     out  1       one-cycle completion pulse for requester 0
//  m0_addr      in   32      byte address
//  m0_wdata     in   DW      write data
//  m0_wstrb     in   NB_COL  byte write strobes; 0 = read
//  m0_rdata     out  DW      read data; valid only while m0_ready=1
//  m1_*         same set as m0_*, requester 1
//  sram_ena     out  1       SRAM enable
//  sram_wea     out  NB_COL  SRAM byte write enables
//  sram_addra   out  AW      SRAM word address
//  sram_dina    out  DW      SRAM write data
//  sram_douta   in   DW      SRAM read data; valid the cycle after sram_ena=1
// BEHAVIOUR
//  - Reset: state IDLE; last_grant=1, so m0 wins the first tie; all outputs 0. Reset is async.
//  - Word address: mX_addr[AW+log2(NB_COL)-1 : log2(NB_COL)]. Upper bits are ignored, so addresses alias modulo RAM.
//  - FSM IDLE -> ACCESS -> RESP. All SRAM-side outputs and ready are registered.
//    IDLE: if any valid, pick the winner, latch addr/wdata/wstrb/grant, go to ACCESS.
//      Both valid: grant != last_grant. Single valid: grant it.
//    ACCESS: sram_ena=1, sram_wea=latched wstrb, sram_addra/dina=latched values.
//      Lasts 1 cycle, then RESP; update last_grant.
//    RESP: sram_ena=0, wea=0; m<grant>_ready=1 for this cycle only.
//      If the other requester is valid, latch it and go to ACCESS. Else go to IDLE.
//      The just-served requester is never re-granted from RESP; its valid is still high this cycle.
//  - Latency: valid rises in cycle 0 (IDLE) -> sram_ena in cycle 1 -> ready in cycle 2.
//    Back-to-back alternate grants give 1 access per 2 cycles.
//  - m0_rdata = m1_rdata = sram_douta (broadcast); only ready qualifies it.
//    For writes, rdata is the pre-write word; requesters ignore it.
//  - sram_dina/addra/wea may hold stale values while sram_ena=0; when sram_ena=0, sram_wea is forced to 0.
//  - Dropping valid before ready is a protocol violation. The latched access still completes and ready still pulses.
//  - Reset mid-operation: outputs go to 0 immediately and the transfer is aborted with no ready.
//    A write whose sram_ena edge was already sampled has already landed.
// STRUCTURE
//  - Shared header sram_defs.vh: FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and the clogb2 function,
//    reused by the SRAM model.
//  - Sub-module rr_arb2: 2-way round-robin picker. Inputs req[1:0], last; outputs gnt, any. Purely combinational.
//  - Top: FSM, request latches, output registers, rdata broadcast.
// TESTING
//  1 Hold resetn=0, then release with no valid -> every output stays 0 for 20 cycles.
//  2 m0 write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> cycle1: ena=1, addra=4, wea=0xF, dina=0xDEADBEEF;
//    cycle2: m0_ready=1. Then read 0x10 -> m0_rdata=0xDEADBEEF while ready.
//  3 m1 write wstrb=0x2, wdata=0x0000AA00 to 0x10 -> m0 read of 0x10 returns 0xDEADAAEF.
//  4 m0 and m1 both valid from reset, each re-raised after its ready -> order m0, m1, m0, m1.
//    Readies land 2 cycles apart; no grant is ever repeated from RESP.
//  5 Assert resetn=0 during ACCESS -> sram_ena falls without a clock edge and no ready occurs.
//    After release, a fresh m1 read completes normally.
//  6 Read addr 0x0000_8010 (RAM_DEPTH=8192) -> addra=4 (alias) and returns the word written in test 2.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding and the
// address-width helper that is also used by the SRAM model.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Number of bits needed to represent value (clogb2(8191) = 13)
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 32'sd0;
    while (v > 32'sd0) begin
      v    = v / 32'sd2;
      bits = bits + 32'sd1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_arbiter_chk.sv
// Protocol checker bound into the arbiter: simulation-only properties on the
// SRAM-side strobes and the requester completion pulses.
module sram_arbiter_chk #(
  parameter int NB_COL = 4
) (
  input logic              clk,
  input logic              resetn,
  input logic              sram_ena,
  input logic [NB_COL-1:0] sram_wea,
  input logic              m0_ready,
  input logic              m1_ready
);

  a_wea_gated: assert property (@(posedge clk) disable iff (!resetn)
    !sram_ena |-> (sram_wea == {NB_COL{1'b0}}));

  a_one_ready: assert property (@(posedge clk) disable iff (!resetn)
    !(m0_ready && m1_ready));

  a_ena_single: assert property (@(posedge clk) disable iff (!resetn)
    sram_ena |=> !sram_ena);

  a_ready_follows_access: assert property (@(posedge clk) disable iff (!resetn)
    sram_ena |=> (m0_ready || m1_ready));

endmodule

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       any
);

  // Combinational winner selection
  always_comb begin
    any = |req;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port byte-write SRAM between two requesters. Each grant
// spends one ACCESS cycle driving the SRAM and one RESP cycle returning ready.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int  NB_COL    = 4,
  parameter int  COL_WIDTH = 8,
  parameter int  RAM_DEPTH = 8192,
  localparam int AW        = clogb2(RAM_DEPTH - 32'sd1),
  localparam int DW        = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [31:0]       m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [NB_COL-1:0] m0_wstrb,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [31:0]       m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [NB_COL-1:0] m1_wstrb,
  output logic [DW-1:0]     m1_rdata,
  output logic              sram_ena,
  output logic [NB_COL-1:0] sram_wea,
  output logic [AW-1:0]     sram_addra,
  output logic [DW-1:0]     sram_dina,
  input  logic [DW-1:0]     sram_douta
);

  localparam int LB = clogb2(NB_COL - 32'sd1);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic              grant_r;
  logic              last_grant_r;
  logic [1:0]        req_s;
  logic              arb_gnt_s;
  logic              arb_any_s;
  logic [AW-1:0]     sel_addr_s;
  logic [DW-1:0]     sel_wdata_s;
  logic [NB_COL-1:0] sel_wstrb_s;
  logic              ena_nxt_s;
  logic [NB_COL-1:0] wea_nxt_s;
  logic [AW-1:0]     addra_nxt_s;
  logic [DW-1:0]     dina_nxt_s;
  logic              m0_ready_nxt_s;
  logic              m1_ready_nxt_s;
  logic              grant_nxt_s;
  logic              last_grant_nxt_s;
  logic              unused_addr_s;

  // Upper address bits alias modulo the RAM size and are deliberately dropped
  assign unused_addr_s = ^{m0_addr, m1_addr};

  // Read data is broadcast; only the ready pulse tells a requester it is theirs
  assign m0_rdata = sram_douta;
  assign m1_rdata = sram_douta;

  // From RESP only the requester not just served may be picked
  always_comb begin
    case (state_r)
      ST_IDLE: req_s = {m1_valid, m0_valid};
      ST_RESP: req_s = {m1_valid & ~grant_r, m0_valid & grant_r};
      default: req_s = 2'b00;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req  (req_s),
    .last (last_grant_r),
    .gnt  (arb_gnt_s),
    .any  (arb_any_s)
  );

  // Request mux feeding the SRAM-side registers
  always_comb begin
    if (arb_gnt_s) begin
      sel_addr_s  = m1_addr[AW+LB-1:LB];
      sel_wdata_s = m1_wdata;
      sel_wstrb_s = m1_wstrb;
    end else begin
      sel_addr_s  = m0_addr[AW+LB-1:LB];
      sel_wdata_s = m0_wdata;
      sel_wstrb_s = m0_wstrb;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_any_s) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: next_state_s = ST_RESP;
      ST_RESP: begin
        if (arb_any_s) begin
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values for the registered SRAM side and readies
  always_comb begin
    ena_nxt_s        = 1'b0;
    wea_nxt_s        = {NB_COL{1'b0}};
    addra_nxt_s      = sram_addra;
    dina_nxt_s       = sram_dina;
    m0_ready_nxt_s   = 1'b0;
    m1_ready_nxt_s   = 1'b0;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (arb_any_s) begin
          ena_nxt_s   = 1'b1;
          wea_nxt_s   = sel_wstrb_s;
          addra_nxt_s = sel_addr_s;
          dina_nxt_s  = sel_wdata_s;
          grant_nxt_s = arb_gnt_s;
        end else begin
          ena_nxt_s   = 1'b0;
        end
      end
      ST_ACCESS: begin
        m0_ready_nxt_s   = ~grant_r;
        m1_ready_nxt_s   = grant_r;
        last_grant_nxt_s = grant_r;
      end
      default: begin
        ena_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and grant registers; reset aborts any transfer without a ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_ena     <= 1'b0;
      sram_wea     <= {NB_COL{1'b0}};
      sram_addra   <= {AW{1'b0}};
      sram_dina    <= {DW{1'b0}};
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      sram_ena     <= ena_nxt_s;
      sram_wea     <= wea_nxt_s;
      sram_addra   <= addra_nxt_s;
      sram_dina    <= dina_nxt_s;
      m0_ready     <= m0_ready_nxt_s;
      m1_ready     <= m1_ready_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  sram_arbiter_chk #(
    .NB_COL (NB_COL)
  ) u_chk (
    .clk      (clk),
    .resetn   (resetn),
    .sram_ena (sram_ena),
    .sram_wea (sram_wea),
    .m0_ready (m0_ready),
    .m1_ready (m1_ready)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, scoreboard of
// expected completions, a vector table and hand-written timing sequences.
module tb_sram_arbiter;

  localparam int NB_COL = 4;
  localparam int DW     = 32;
  localparam int AW     = 13;
  localparam int DEPTH  = 8192;

  logic              clk;
  logic              resetn;
  logic              m0_valid, m1_valid;
  logic              m0_ready, m1_ready;
  logic [31:0]       m0_addr, m1_addr;
  logic [DW-1:0]     m0_wdata, m1_wdata;
  logic [NB_COL-1:0] m0_wstrb, m1_wstrb;
  logic [DW-1:0]     m0_rdata, m1_rdata;
  logic              sram_ena;
  logic [NB_COL-1:0] sram_wea;
  logic [AW-1:0]     sram_addra;
  logic [DW-1:0]     sram_dina;
  logic [DW-1:0]     sram_douta;
  logic [DW-1:0]     mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        port;
    logic        chk;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] rdata;
    logic [12:0] addra;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_item;
  vec_t vecs[13];

  sram_arbiter #(
    .NB_COL    (4),
    .COL_WIDTH (8),
    .RAM_DEPTH (8192)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_rdata   (m1_rdata),
    .sram_ena   (sram_ena),
    .sram_wea   (sram_wea),
    .sram_addra (sram_addra),
    .sram_dina  (sram_dina),
    .sram_douta (sram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, byte writes, zero output when not enabled
  initial begin
    sram_douta = 32'd0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
  end
  always @(posedge clk) begin
    if (sram_ena) begin
      sram_douta <= mem[sram_addra];
      for (int b = 0; b < NB_COL; b++)
        if (sram_wea[b]) mem[sram_addra][b*8 +: 8] <= sram_dina[b*8 +: 8];
    end else begin
      sram_douta <= 32'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] quiet_bits();
    return 32'({sram_ena, sram_wea, m0_ready, m1_ready,
                |sram_addra, |sram_dina, |m0_rdata, |m1_rdata});
  endfunction

  // Scoreboard: every ready pulse retires the oldest expected completion
  always @(posedge clk) begin
    #1;
    if (m0_ready || m1_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: m0_ready=%0b m1_ready=%0b with nothing outstanding", m0_ready, m1_ready);
      end else begin
        sb_item = sb_q.pop_front();
        check("ready_port", 32'({m1_ready, m0_ready}), sb_item.port ? 32'd2 : 32'd1);
        if (sb_item.chk) check("rdata", sb_item.port ? m1_rdata : m0_rdata, sb_item.rdata);
      end
    end
  end

  task automatic push_exp(input logic p, input logic c, input logic [31:0] r);
    exp_t e;
    e.port  = p;
    e.chk   = c;
    e.rdata = r;
    sb_q.push_back(e);
  endtask

  task automatic run_req(input string name, input vec_t v);
    bit got;
    push_exp(v.port, v.chk, v.rdata);
    if (v.port) begin
      m1_valid = 1'b1; m1_addr = v.addr; m1_wdata = v.wdata; m1_wstrb = v.wstrb;
    end else begin
      m0_valid = 1'b1; m0_addr = v.addr; m0_wdata = v.wdata; m0_wstrb = v.wstrb;
    end
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (v.port ? m1_ready : m0_ready) got = 1'b1;
    end
    if (got) begin
      check({name, "_addra"}, 32'(sram_addra), 32'(v.addra));
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: ready=0 after 8 cycles, required ready=1", name);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, nready;

    //            port  addr           wdata          wstrb chk   rdata          addra
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 1'b0, 32'h0000_0000, 13'd4};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_AAEF, 13'd4};
    vecs[2]  = '{1'b1, 32'h0000_8010, 32'h0000_0000, 4'h0, 1'b1, 32'hDEAD_AAEF, 13'd4};
    vecs[3]  = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, 1'b0, 32'h0000_0000, 13'd8};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0000_0000, 13'd8};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 1'b1, 32'h1234_56FF, 13'd8};
    vecs[6]  = '{1'b1, 32'h0000_7FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000, 13'd8191};
    vecs[7]  = '{1'b0, 32'h0000_7FFC, 32'h0000_0000, 4'h0, 1'b1, 32'hCAFE_F00D, 13'd8191};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 1'b1, 32'hCAFE_F00D, 13'd8191};
    vecs[9]  = '{1'b0, 32'h0000_0024, 32'hA5A5_0000, 4'hC, 1'b0, 32'h0000_0000, 13'd9};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'h0, 1'b1, 32'hA5A5_0000, 13'd9};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 1'b1, 32'h0000_0000, 13'd0};
    vecs[12] = '{1'b0, 32'h0000_0026, 32'h0000_0000, 4'h0, 1'b1, 32'hA5A5_0000, 13'd9};

    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'h0;

    // Reset and quiet idle
    repeat (3) tick();
    check("reset_hold", quiet_bits(), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_quiet", quiet_bits(), 32'd0);
    end

    // Single write with cycle-exact latency, then read back
    push_exp(1'b0, 1'b0, 32'd0);
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'hF;
    tick();
    check("c1_ena", 32'(sram_ena), 32'd1);
    check("c1_addra", 32'(sram_addra), 32'd4);
    check("c1_wea", 32'(sram_wea), 32'hF);
    check("c1_dina", sram_dina, 32'hDEAD_BEEF);
    check("c1_ready", 32'(m0_ready), 32'd0);
    tick();
    check("c2_ready", 32'(m0_ready), 32'd1);
    check("c2_ena_wea", 32'({sram_ena, sram_wea}), 32'd0);
    m0_valid = 1'b0;
    tick();
    run_req("rd_deadbeef", '{1'b0, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEAD_BEEF, 13'd4});

    // Vector table: byte strobes, aliasing, boundary words
    foreach (vecs[i]) run_req($sformatf("vec%0d", i), vecs[i]);

    // Both requesters valid from reset: strict alternation, readies 2 cycles apart
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    push_exp(1'b0, 1'b1, 32'hDEAD_AAEF);
    push_exp(1'b1, 1'b1, 32'hA5A5_0000);
    push_exp(1'b0, 1'b1, 32'h1234_56FF);
    push_exp(1'b1, 1'b1, 32'hCAFE_F00D);
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h24; m1_wstrb = 4'h0;
    n0 = 0; n1 = 0; nready = 0;
    for (int k = 1; k <= 16 && nready < 4; k++) begin
      tick();
      if (m0_ready || m1_ready) begin
        nready++;
        check("rr_ready_cycle", 32'(k), 32'(2 * nready));
        if (m0_ready) begin
          if (n0 == 0) m0_addr = 32'h20; else m0_valid = 1'b0;
          n0++;
        end
        if (m1_ready) begin
          if (n1 == 0) m1_addr = 32'h7FFC; else m1_valid = 1'b0;
          n1++;
        end
      end
    end
    check("rr_ready_count", 32'(nready), 32'd4);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();

    // Reset during ACCESS: outputs drop without a clock edge, write never lands
    m0_valid = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h5555_5555; m0_wstrb = 4'hF;
    tick();
    check("abort_in_access", 32'(sram_ena), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_async", quiet_bits(), 32'd0);
    m0_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ready", 32'({m0_ready, m1_ready}), 32'd0);
    end
    run_req("post_reset_rd", '{1'b1, 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEAD_AAEF, 13'd4});
    run_req("aborted_wr_absent", '{1'b1, 32'h30, 32'd0, 4'h0, 1'b1, 32'h0000_0000, 13'd12});

    repeat (3) tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
